// File: rtl/frag_pkg.sv
// Shared types and constants for the fragment write scheduler.
package frag_pkg;

  typedef enum logic [1:0] {IDLE, XFER, PAD, DONE} state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int PK_DEPTH_BYTES = 16;

  // Byte count of a single packer write, 0..4
  typedef logic [2:0] bcnt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot winner, pointer moves to the
// finishing owner when upd_i is pulsed.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               upd_i,
  input  logic [NUM_REQ-1:0] upd_gnt_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0] last_q, last_d;
  logic             found;

  always_comb begin
    last_d = last_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (upd_gnt_i[i]) last_d = IDX_W'(i);
    end
  end

  // Scan starts just after the last owner, so it has lowest priority
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_i[i] && (i == (int'(last_q) + k) % NUM_REQ)) begin
          gnt_o[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= IDX_W'(NUM_REQ - 1);
    end else if (upd_i) begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/frag_wr_sched.sv
// Grants the write packer to one fragment source at a time and slices the
// fragment into packer writes, padding the tail to a 4-byte boundary.
module frag_wr_sched
  import frag_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int LEN_W        = 12,
  parameter int PAD_EN       = 1,
  parameter int THROTTLE_LVL = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ*32-1:0]    req_data,
  input  logic [NUM_REQ-1:0]       req_data_valid,
  output logic [NUM_REQ-1:0]       req_data_ready,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       frag_done,
  output logic [31:0]              pk_din,
  output logic [3:0]               pk_din_index,
  output logic                     pk_wr_en,
  input  logic [3:0]               pk_level,
  output logic                     busy
);

  localparam logic [4:0] THR = 5'(THROTTLE_LVL);

  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q, frag_done_q, arb_gnt;
  logic [LEN_W-1:0]   rem_q, rem_d, win_len;
  logic [1:0]         cnt_q, cnt_d;
  logic [31:0]        din_q, data_sel;
  bcnt_t              idx_q, nb;
  logic               wr_en_q, xfer_rdy, accept;

  // Bytes taken by the next word, without underflow when rem < 4
  function automatic bcnt_t min4(input logic [LEN_W-1:0] r);
    if (r >= LEN_W'(BYTES_PER_WORD)) return bcnt_t'(BYTES_PER_WORD);
    return bcnt_t'(r);
  endfunction

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_valid),
    .upd_i     (state_q == DONE),
    .upd_gnt_i (grant_q),
    .gnt_o     (arb_gnt)
  );

  assign xfer_rdy       = (state_q == XFER) && (rem_q != '0) && ({1'b0, pk_level} < THR);
  assign req_data_ready = grant_q & {NUM_REQ{xfer_rdy}};
  assign accept         = |(req_data_ready & req_data_valid);
  assign nb             = min4(rem_q);
  assign rem_d          = rem_q - LEN_W'(nb);
  assign cnt_d          = cnt_q + nb[1:0];

  always_comb begin
    data_sel = '0;
    win_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) data_sel = data_sel | req_data[i*32 +: 32];
      if (arb_gnt[i]) win_len  = win_len | req_len[i*LEN_W +: LEN_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      frag_done_q <= '0;
      wr_en_q     <= 1'b0;
      din_q       <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
    end else begin
      wr_en_q     <= 1'b0;
      idx_q       <= '0;
      frag_done_q <= '0;
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            grant_q <= arb_gnt;
            rem_q   <= win_len;
            cnt_q   <= '0;
            state_q <= (win_len == '0) ? DONE : XFER;
          end
        end
        XFER: begin
          if (accept) begin
            wr_en_q <= 1'b1;
            din_q   <= data_sel;
            idx_q   <= nb;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            if (rem_d == '0) state_q <= (PAD_EN != 0 && cnt_d != 2'd0) ? PAD : DONE;
          end
        end
        PAD: begin
          wr_en_q <= 1'b1;
          din_q   <= '0;
          idx_q   <= bcnt_t'(BYTES_PER_WORD) - {1'b0, cnt_q};
          state_q <= DONE;
        end
        DONE: begin
          frag_done_q <= grant_q;
          grant_q     <= '0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant        = grant_q;
  assign frag_done    = frag_done_q;
  assign pk_din       = din_q;
  assign pk_din_index = {1'b0, idx_q};
  assign pk_wr_en     = wr_en_q;
  assign busy         = (state_q != IDLE);

endmodule
